register_interpreter: RTL and testbench
=======================================

REGISTER_INTERPRETER -- requirements
Module: register_interpreter

Interface
REQ-001 Parameter: ACCEPT_PAREN, default 1; when 1, ")" (0x29) is a valid terminating delimiter, used for load/store operands such as "4(x2)".
REQ-002 clk_in  input  1  single clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-low.
REQ-004 valid_data  input  1  high while an operand token is being streamed; low aborts to IDLE.
REQ-005 new_character  input  1  incoming_ascii holds a fresh character this cycle.
REQ-006 incoming_ascii  input  8  ASCII character.
REQ-007 reg_index  output  5  decoded register number x0..x31.
REQ-008 done_flag  output  1  one-cycle pulse: token decoded, reg_index valid.
REQ-009 error_flag  output  1  high while in ERROR.
REQ-010 busy_flag  output  1  high whenever state is not IDLE.

Function
REQ-011 A character is accepted only in cycles with valid_data=1 and new_character=1; otherwise the state and buffer hold, except as given in REQ-012.
REQ-012 valid_data=0 in any cycle forces IDLE on the next edge, regardless of state.
REQ-013 States are IDLE, ACCUM, RETURN and ERROR; done_flag = (RETURN), error_flag = (ERROR), busy_flag = (state != IDLE).
REQ-014 Letters are case-insensitive; the buffer stores lower-case ASCII, up to 4 characters.
REQ-015 IDLE, on accepted character:
- space: stay IDLE.
- letter or digit: go to ACCUM with buffer = {char}, count = 1.
- anything else: go to ERROR.
REQ-016 ACCUM, on accepted character:
- letter or digit with count < 4: append, count += 1.
- letter or digit with count = 4: go to ERROR.
- delimiter (space, ",", 0x0A, or ")" if ACCEPT_PAREN = 1), buffer a legal name: go to RETURN and latch reg_index.
- delimiter, buffer not a legal name: go to ERROR.
- any other character: go to ERROR.
REQ-017 Latency: delimiter accepted at edge N, so done_flag is high for exactly the cycle following edge N and falls at edge N+1.
REQ-018 RETURN lasts one cycle, then goes to IDLE; a character accepted during RETURN is processed exactly as IDLE would process it (back-to-back tokens are legal).
REQ-019 ERROR is sticky until valid_data=0 or reset.
REQ-020 Numeric names: "x" followed by one digit, or by two digits with the first nonzero, value 0..31. "x32" through "x99" and "x05" are illegal.
REQ-021 ABI names (gated by REQ-026):
- zero=0, ra=1, sp=2, gp=3, tp=4
- t0-t2 = 5-7; s0 and fp = 8; s1 = 9
- a0-a7 = 10-17; s2-s11 = 18-27; t3-t6 = 28-31
REQ-022 reg_index holds its last latched value until the next successful decode; it is not cleared on error or abort.
REQ-023 A delimiter arriving in IDLE, before any name character, other than space leads to ERROR; the empty token is illegal.

Reset
REQ-024 While rst_in=0 at a clock edge: state = IDLE, buffer cleared, count = 0, reg_index = 0, so done_flag = error_flag = busy_flag = 0.
REQ-025 Reset mid-token discards the partial token; the first accepted character after rst_in returns high is treated as IDLE input.

Configuration
REQ-026 Macro ABI_NAMES_EN:
- Defined: both the numeric names (REQ-020) and the ABI names (REQ-021) are legal.
- Undefined: only numeric names are legal; any ABI name, including "zero" and "fp", leads to ERROR at the delimiter, and the ABI decode logic is absent.

Verification
REQ-027 Reset, then stream "x5," with valid_data=1 -> done_flag pulses one cycle after ","; reg_index=5; error_flag stays 0.
REQ-028 With ABI_NAMES_EN defined, stream "sp " then "s11)" with ACCEPT_PAREN=1 -> two done pulses; reg_index=2, then 27.
REQ-029 Stream "x32 " and, separately, "x05," -> error_flag rises after the delimiter and stays high until valid_data=0, then the block returns to IDLE.
REQ-030 Stream "zer", then drop valid_data for one cycle, then stream "a0," -> no error; done pulse; reg_index=10 (ABI_NAMES_EN defined).
REQ-031 Without ABI_NAMES_EN, stream "zero," -> error_flag=1 and no done pulse; then reset mid-token "x1" -> all flags 0 and reg_index=0.
REQ-032 Stream "x1,x2," with new_character high on consecutive cycles -> done pulses with reg_index=1, then 2; the "x" accepted during RETURN is not lost.

Source files
------------

// File: rtl/register_interpreter.sv
// register_interpreter: decodes a streamed RISC-V register operand ("x5", "sp", "s11", ...) into x0..x31.
// Latency: reg_index and done_flag are valid the cycle after the terminating delimiter is accepted.
// Backpressure: none; a character is consumed whenever valid_data and new_character are both high.
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          synchronous active-low reset
//   valid_data      token framing; low aborts to IDLE on the next edge
//   new_character   incoming_ascii carries a fresh character this cycle
//   incoming_ascii  8-bit ASCII character
//   reg_index       last successfully decoded register number (held across errors/aborts)
//   done_flag       one-cycle pulse while in RETURN
//   error_flag      high while in ERROR (sticky until valid_data drops or reset)
//   busy_flag       high whenever the FSM is not IDLE
//
// Configuration: define ABI_NAMES_EN to also accept ABI register names (zero, ra, sp, a0, s11, ...).
// Parameter ACCEPT_PAREN=1 makes ")" a valid delimiter for load/store operands like "4(x2)".
module register_interpreter #(
    parameter int ACCEPT_PAREN = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_data,
    input  logic       new_character,
    input  logic [7:0] incoming_ascii,
    output logic [4:0] reg_index,
    output logic       done_flag,
    output logic       error_flag,
    output logic       busy_flag
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_RETURN = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t      state_q;
    // Characters are shifted in at the low byte, so a complete token lines up
    // with a right-justified string literal ("sp" == 32'h0000_7370).
    logic [31:0] buf_q;
    logic [2:0]  cnt_q;
    logic [4:0]  idx_q;

    logic [7:0]  lc_char;
    logic        is_letter;
    logic        is_digit;
    logic        is_alnum;
    logic        is_space;
    logic        is_delim;

    // Character classification on the lower-cased input.
    always_comb begin
        lc_char = incoming_ascii;
        if (incoming_ascii >= "A" && incoming_ascii <= "Z") begin
            lc_char = incoming_ascii | 8'h20;
        end
        is_letter = (lc_char >= "a") && (lc_char <= "z");
        is_digit  = (lc_char >= "0") && (lc_char <= "9");
        is_alnum  = is_letter || is_digit;
        is_space  = (lc_char == 8'h20);
        is_delim  = is_space || (lc_char == ",") || (lc_char == 8'h0A) ||
                    ((ACCEPT_PAREN != 0) && (lc_char == ")"));
    end

    // Name decode of the buffered token.
    logic [3:0]  d_lo;
    logic [3:0]  d_hi;
    logic        lo_dig;
    logic        hi_dig;
    logic [6:0]  num_val;
    logic        name_legal;
    logic [4:0]  name_idx;

`ifdef ABI_NAMES_EN
    logic        abi_legal;
    logic [4:0]  abi_idx;

    always_comb begin
        abi_legal = 1'b0;
        abi_idx   = 5'd0;
        if (buf_q == "zero") begin
            abi_legal = 1'b1;
            abi_idx   = 5'd0;
        end else if (buf_q[31:16] == 16'h0) begin
            case (buf_q[15:0])
                "ra": begin abi_legal = 1'b1; abi_idx = 5'd1; end
                "sp": begin abi_legal = 1'b1; abi_idx = 5'd2; end
                "gp": begin abi_legal = 1'b1; abi_idx = 5'd3; end
                "tp": begin abi_legal = 1'b1; abi_idx = 5'd4; end
                "fp": begin abi_legal = 1'b1; abi_idx = 5'd8; end
                default: begin
                    if (lo_dig) begin
                        case (buf_q[15:8])
                            "t": begin
                                if (d_lo <= 4'd2) begin
                                    abi_legal = 1'b1;
                                    abi_idx   = 5'd5 + {1'b0, d_lo};
                                end else if (d_lo <= 4'd6) begin
                                    abi_legal = 1'b1;
                                    abi_idx   = 5'd25 + {1'b0, d_lo};
                                end
                            end
                            // s0/s1 map to 8/9; s2..s9 jump to 18..25.
                            "s": begin
                                abi_legal = 1'b1;
                                abi_idx   = (d_lo < 4'd2) ? (5'd8 + {1'b0, d_lo})
                                                          : (5'd16 + {1'b0, d_lo});
                            end
                            "a": begin
                                if (d_lo <= 4'd7) begin
                                    abi_legal = 1'b1;
                                    abi_idx   = 5'd10 + {1'b0, d_lo};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end else if (buf_q[31:24] == 8'h0 && buf_q[23:8] == "s1" &&
                     (buf_q[7:0] == "0" || buf_q[7:0] == "1")) begin
            abi_legal = 1'b1;
            abi_idx   = 5'd26 + {1'b0, d_lo};
        end
    end
`endif

    always_comb begin
        d_lo       = buf_q[3:0];
        d_hi       = buf_q[11:8];
        lo_dig     = (buf_q[7:0] >= "0") && (buf_q[7:0] <= "9");
        hi_dig     = (buf_q[15:8] >= "0") && (buf_q[15:8] <= "9");
        num_val    = {3'b0, d_hi} * 7'd10 + {3'b0, d_lo};
        name_legal = 1'b0;
        name_idx   = 5'd0;
        if (buf_q[31:16] == 16'h0 && buf_q[15:8] == "x" && lo_dig) begin
            name_legal = 1'b1;
            name_idx   = {1'b0, d_lo};
        end else if (buf_q[31:24] == 8'h0 && buf_q[23:16] == "x" && hi_dig && lo_dig &&
                     buf_q[15:8] != "0" && num_val <= 7'd31) begin
            // Two-digit form: no leading zero, value capped at 31.
            name_legal = 1'b1;
            name_idx   = num_val[4:0];
        end
`ifdef ABI_NAMES_EN
        else if (abi_legal) begin
            name_legal = 1'b1;
            name_idx   = abi_idx;
        end
`endif
    end

    logic [31:0] buf_d;
    assign buf_d = {buf_q[23:0], lc_char};

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            buf_q   <= 32'h0;
            cnt_q   <= 3'd0;
            idx_q   <= 5'd0;
        end else if (!valid_data) begin
            state_q <= S_IDLE;
            buf_q   <= 32'h0;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                // RETURN behaves like IDLE for the incoming character so
                // back-to-back tokens lose nothing.
                S_IDLE, S_RETURN: begin
                    state_q <= S_IDLE;
                    if (new_character) begin
                        if (is_space) begin
                            state_q <= S_IDLE;
                        end else if (is_alnum) begin
                            state_q <= S_ACCUM;
                            buf_q   <= {24'h0, lc_char};
                            cnt_q   <= 3'd1;
                        end else begin
                            state_q <= S_ERROR;
                        end
                    end
                end
                S_ACCUM: begin
                    if (new_character) begin
                        if (is_alnum) begin
                            if (cnt_q < 3'd4) begin
                                buf_q <= buf_d;
                                cnt_q <= cnt_q + 3'd1;
                            end else begin
                                state_q <= S_ERROR;
                            end
                        end else if (is_delim && name_legal) begin
                            state_q <= S_RETURN;
                            idx_q   <= name_idx;
                        end else begin
                            state_q <= S_ERROR;
                        end
                    end
                end
                default: state_q <= S_ERROR;
            endcase
        end
    end

    assign reg_index  = idx_q;
    assign done_flag  = (state_q == S_RETURN);
    assign error_flag = (state_q == S_ERROR);
    assign busy_flag  = (state_q != S_IDLE);

endmodule

// File: tb/tb_register_interpreter.sv
// tb_register_interpreter: directed-vector bench for register_interpreter.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: none; the bench paces characters itself.
module tb_register_interpreter;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       valid_data = 1'b0;
    logic       new_character = 1'b0;
    logic [7:0] incoming_ascii = 8'h0;
    logic [4:0] reg_index;
    logic       done_flag;
    logic       error_flag;
    logic       busy_flag;

    int vec_cnt = 0;
    int mis_cnt = 0;

    register_interpreter #(.ACCEPT_PAREN(1)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_data     (valid_data),
        .new_character  (new_character),
        .incoming_ascii (incoming_ascii),
        .reg_index      (reg_index),
        .done_flag      (done_flag),
        .error_flag     (error_flag),
        .busy_flag      (busy_flag)
    );

    always #5 clk_in = ~clk_in;

    task automatic drive(input logic [7:0] c);
        @(negedge clk_in);
        valid_data     = 1'b1;
        new_character  = 1'b1;
        incoming_ascii = c;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(s[i]);
    endtask

    task automatic gap();
        @(negedge clk_in);
        new_character = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drop();
        @(negedge clk_in);
        valid_data    = 1'b0;
        new_character = 1'b0;
        @(posedge clk_in);
        #1;
        valid_data = 1'b1;
    endtask

    // Expect a single-cycle done pulse with the given index right after the delimiter.
    task automatic expect_done(input string name, input logic [4:0] idx);
        vec_cnt++;
        if (done_flag !== 1'b1 || error_flag !== 1'b0 || reg_index !== idx) begin
            mis_cnt++;
            $display("FAIL %s: done=%0b err=%0b idx=%0d, want done=1 err=0 idx=%0d",
                     name, done_flag, error_flag, reg_index, idx);
        end
        gap();
        vec_cnt++;
        if (done_flag !== 1'b0 || busy_flag !== 1'b0 || reg_index !== idx) begin
            mis_cnt++;
            $display("FAIL %s_after: done=%0b busy=%0b idx=%0d, want 0 0 %0d",
                     name, done_flag, busy_flag, reg_index, idx);
        end
    endtask

    // Expect ERROR with no done pulse and reg_index unchanged, then abort back to IDLE.
    task automatic expect_err(input string name, input logic [4:0] held_idx);
        vec_cnt++;
        if (error_flag !== 1'b1 || done_flag !== 1'b0 || busy_flag !== 1'b1 || reg_index !== held_idx) begin
            mis_cnt++;
            $display("FAIL %s: err=%0b done=%0b busy=%0b idx=%0d, want 1 0 1 %0d",
                     name, error_flag, done_flag, busy_flag, reg_index, held_idx);
        end
        drop();
        vec_cnt++;
        if (error_flag !== 1'b0 || busy_flag !== 1'b0) begin
            mis_cnt++;
            $display("FAIL %s_abort: err=%0b busy=%0b, want 0 0", name, error_flag, busy_flag);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        valid_data = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        vec_cnt++;
        if ({done_flag, error_flag, busy_flag} !== 3'b000 || reg_index !== 5'd0) begin
            mis_cnt++;
            $display("FAIL reset: flags=%b idx=%0d, want 000 0",
                     {done_flag, error_flag, busy_flag}, reg_index);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_x5();
        send_str("x5");
        vec_cnt++;
        if (busy_flag !== 1'b1 || done_flag !== 1'b0) begin
            mis_cnt++;
            $display("FAIL x5_accum: busy=%0b done=%0b, want 1 0", busy_flag, done_flag);
        end
        drive(",");
        expect_done("x5", 5'd5);
    endtask

    task automatic test_back_to_back();
        send_str("x1,");
        vec_cnt++;
        if (done_flag !== 1'b1 || reg_index !== 5'd1) begin
            mis_cnt++;
            $display("FAIL b2b_first: done=%0b idx=%0d, want 1 1", done_flag, reg_index);
        end
        drive("x");
        vec_cnt++;
        if (done_flag !== 1'b0 || busy_flag !== 1'b1 || error_flag !== 1'b0) begin
            mis_cnt++;
            $display("FAIL b2b_x_kept: done=%0b busy=%0b err=%0b, want 0 1 0",
                     done_flag, busy_flag, error_flag);
        end
        send_str("2,");
        expect_done("b2b_second", 5'd2);
    endtask

    task automatic test_numeric_bounds();
        send_str("X31)");
        expect_done("x31_upper_paren", 5'd31);
        send_str("x0\n");
        expect_done("x0_newline", 5'd0);
        send_str("x19 ");
        expect_done("x19", 5'd19);
        send_str("x9 ");
        expect_done("x9", 5'd9);
    endtask

    task automatic test_errors();
        send_str("x32 ");
        vec_cnt++;
        if (error_flag !== 1'b1) begin
            mis_cnt++;
            $display("FAIL x32_err: err=%0b, want 1", error_flag);
        end
        gap();
        send_str("x1,");
        expect_err("x32_sticky", 5'd9);
        send_str("x05,");
        expect_err("x05", 5'd9);
        drive(",");
        expect_err("empty_token", 5'd9);
        send_str("x123");
        vec_cnt++;
        if (error_flag !== 1'b0 || busy_flag !== 1'b1) begin
            mis_cnt++;
            $display("FAIL four_chars: err=%0b busy=%0b, want 0 1", error_flag, busy_flag);
        end
        drive(" ");
        expect_err("x123_illegal", 5'd9);
        send_str("x1234");
        expect_err("fifth_char", 5'd9);
        send_str("x#");
        expect_err("bad_char", 5'd9);
        drive(" ");
        vec_cnt++;
        if (busy_flag !== 1'b0 || error_flag !== 1'b0) begin
            mis_cnt++;
            $display("FAIL idle_space: busy=%0b err=%0b, want 0 0", busy_flag, error_flag);
        end
        gap();
    endtask

    task automatic test_abort();
        send_str("x1");
        drop();
        vec_cnt++;
        if (busy_flag !== 1'b0 || reg_index !== 5'd9) begin
            mis_cnt++;
            $display("FAIL abort_idle: busy=%0b idx=%0d, want 0 9", busy_flag, reg_index);
        end
        send_str("x7,");
        expect_done("after_abort", 5'd7);
    endtask

    task automatic test_abi();
`ifdef ABI_NAMES_EN
        send_str("sp ");
        expect_done("sp", 5'd2);
        send_str("s11)");
        expect_done("s11", 5'd27);
        send_str("zero,");
        expect_done("zero", 5'd0);
        send_str("fp,");
        expect_done("fp", 5'd8);
        send_str("a7,");
        expect_done("a7", 5'd17);
        send_str("t6,");
        expect_done("t6", 5'd31);
        send_str("s2,");
        expect_done("s2", 5'd18);
        send_str("zer");
        drop();
        send_str("a0,");
        expect_done("zer_drop_a0", 5'd10);
`else
        send_str("zero,");
        expect_err("zero_disabled", 5'd7);
        send_str("sp ");
        expect_err("sp_disabled", 5'd7);
`endif
    endtask

    task automatic test_reset_mid();
        send_str("x1");
        @(negedge clk_in);
        new_character = 1'b0;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        vec_cnt++;
        if ({done_flag, error_flag, busy_flag} !== 3'b000 || reg_index !== 5'd0) begin
            mis_cnt++;
            $display("FAIL reset_mid: flags=%b idx=%0d, want 000 0",
                     {done_flag, error_flag, busy_flag}, reg_index);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        send_str("x3,");
        expect_done("after_reset", 5'd3);
    endtask

    initial begin
        test_reset();
        test_x5();
        test_back_to_back();
        test_numeric_bounds();
        test_errors();
        test_abort();
        test_abi();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
